lsq_load_responder: RTL and testbench
=====================================

# lsq_load_responder

Memory-side end of the load port channel. It accepts load addresses arriving on the address channel (channel 1 of the load operation), issues reads to a single-port synchronous-read memory, and returns the read data in order on the data channel (channel 0). At most DEPTH loads are in flight; buffering guarantees no returned datum is lost under output backpressure.

## Interface
- DATA_SIZE, 32, width of load data
- ADDRESS_SIZE, 32, width of load address
- DEPTH, 4, maximum outstanding loads (issued but not yet consumed); power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- addr_in  in  ADDRESS_SIZE  load address from circuit
- addr_valid  in  1  addr_in valid
- addr_ready  out  1  responder accepts address this cycle
- data_out  out  DATA_SIZE  load result to circuit
- data_valid  out  1  data_out valid
- data_ready  in  1  circuit consumes data_out
- mem_re  out  1  memory read enable
- mem_addr  out  ADDRESS_SIZE  memory read address
- mem_rdata  in  DATA_SIZE  memory read data, valid exactly one cycle after mem_re

## Operation
- accept = addr_valid & addr_ready; pop = data_valid & data_ready.
- credit register cnt (0..DEPTH, width $clog2(DEPTH)+1) counts accepted-but-not-popped loads; +1 on accept, −1 on pop, unchanged when both occur.
- addr_ready = !rst & (cnt < DEPTH); depends only on registered state, never on data_ready or addr_valid.
- mem_re = accept; mem_addr = addr_in (combinational pass-through, no added latency).
- rd_pend register = accept of previous cycle; when rd_pend=1, mem_rdata is pushed into the in-order FIFO (DEPTH entries, wrapping read/write pointers).
- data_out = FIFO head; data_valid = FIFO not empty.
- FIFO can never overflow: cnt ≥ FIFO occupancy + rd_pend, and cnt ≤ DEPTH.
- Ordering: data returned strictly in address-acceptance order.
- Push and pop in the same cycle are both performed; on a full FIFO, pop frees the slot at the next edge, not combinationally.

## Timing
- Reset values: addr_ready=0 while rst=1, 1 on the first cycle after; data_valid=0; mem_re=0; cnt=0; rd_pend=0; pointers=0.
- Latency, accept to data_valid: 2 cycles (memory cycle + FIFO write) without bypass; 1 cycle with bypass on an empty FIFO.
- Throughput: one load per cycle sustained when data_ready=1 and DEPTH ≥ 3 (no bypass) or ≥ 2 (bypass).
- data_out/data_valid are held stable while data_valid=1 and data_ready=0.
- Full: cnt=DEPTH → addr_ready=0; a pop that cycle re-enables addr_ready on the next cycle.
- Reset mid-operation: in-flight read dropped (rd_pend cleared; mem_rdata arriving the cycle after reset is ignored), FIFO emptied, cnt=0.

## Configuration
- LSQ_LOAD_BYPASS_EN defined: when rd_pend=1 and the FIFO is empty, mem_rdata drives data_out with data_valid=1 in the same cycle; if popped, it is not written to the FIFO, otherwise it is written as usual.
- Undefined: data_out always comes from a FIFO register; no combinational path from mem_rdata to data_out.

## Structure
- Shared package lsq_pkg: default width constants (DATA_SIZE, ADDRESS_SIZE), the credit-width function based on $clog2(DEPTH)+1, and the memory read latency constant MEM_RD_LAT=1.
- One sub-module, lsq_resp_fifo: parameterised DATA_SIZE/DEPTH synchronous FIFO with push, pop, head, empty, full outputs. The top-level holds the credit counter, rd_pend and the bypass mux.

## Test plan
- Single load: addr 0x10 accepted in cycle 0, memory returns 0xDEADBEEF → mem_re=1 in cycle 0; data_valid=1 with 0xDEADBEEF in cycle 2 (cycle 1 with bypass); cnt returns to 0 after the pop.
- Back-to-back: addrs 0,4,8,12 on consecutive cycles, data_ready=1, memory returns addr+0x100 → outputs 0x100,0x104,0x108,0x10C in order, no bubbles.
- Backpressure/full: DEPTH=4, data_ready=0, addr_valid=1 continuously → exactly 4 accepts, then addr_ready=0; raise data_ready for 1 cycle → one pop, addr_ready=1 on the next cycle, one new accept.
- Simultaneous accept+pop at cnt=2 → cnt stays at 2, FIFO order preserved.
- Reset mid-flight: accept in cycle 0, rst=1 in cycle 1 → data_valid stays 0, cnt=0, the stale mem_rdata is not delivered afterwards.
- Macro on/off: same stimulus with and without LSQ_LOAD_BYPASS_EN → identical data sequence; latency differs by exactly 1 cycle on an empty FIFO.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared definitions for the load-store queue load port: default widths,
// the credit counter width helper and the memory read latency.
package lsq_pkg;

    localparam int LSQ_DATA_SIZE    = 32;
    localparam int LSQ_ADDRESS_SIZE = 32;
    localparam int LSQ_DEPTH        = 4;
    localparam int MEM_RD_LAT       = 1;

    // A credit counter must hold 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lsq_resp_fifo.sv
// In-order response FIFO for the load responder. Storage is a small register
// array so the head is available combinationally (no read latency), which is
// what keeps accept-to-data at two cycles.
module lsq_resp_fifo
    import lsq_pkg::*;
#(
    parameter int DATA_SIZE = LSQ_DATA_SIZE,
    parameter int DEPTH     = LSQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head,
    output logic                 empty,
    output logic                 full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic [DATA_SIZE-1:0] slot_array [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slot_array[rd_ptr_reg];

    // One storage slot per entry; only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [DATA_SIZE-1:0] slot_reg;

            // Capture pushed data into this slot when it is the write target.
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PW'(gi))) begin
                    slot_reg <= din;
                end
            end

            assign slot_array[gi] = slot_reg;
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lsq_load_responder.sv
// Memory-side end of the load port: accepts load addresses, reads a
// single-port synchronous-read memory and returns data in order.
// Optional feature: define LSQ_LOAD_BYPASS_EN to forward memory read data
// straight to data_out when the response FIFO is empty (saves one cycle).
module lsq_load_responder
    import lsq_pkg::*;
#(
    parameter int DATA_SIZE    = LSQ_DATA_SIZE,
    parameter int ADDRESS_SIZE = LSQ_ADDRESS_SIZE,
    parameter int DEPTH        = LSQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] addr_in,
    input  logic                    addr_valid,
    output logic                    addr_ready,
    output logic [DATA_SIZE-1:0]    data_out,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    mem_re,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0]    mem_rdata
);

    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0]         cnt_reg;
    logic [MEM_RD_LAT-1:0] rd_pend_reg;
    logic                  rd_pend;
    logic                  accept;
    logic                  pop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_SIZE-1:0]  fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Credits bound the in-flight loads, so the FIFO can never overflow;
    // fifo_full can only be set when cnt is already DEPTH, so it is redundant
    // but keeps the FIFO guard explicit.
    assign addr_ready = ~rst & (cnt_reg < CW'(DEPTH)) & ~fifo_full;
    assign accept     = addr_valid & addr_ready;
    assign mem_re     = accept;
    assign mem_addr   = addr_in;
    assign rd_pend    = rd_pend_reg[MEM_RD_LAT-1];
    assign pop        = data_valid & data_ready;

`ifdef LSQ_LOAD_BYPASS_EN
    logic bypass_active;

    // Forward the returning read when nothing older is queued; only write it
    // into the FIFO if the consumer did not take it this cycle.
    always_comb begin
        bypass_active = rd_pend & fifo_empty & ~rst;
        data_out      = bypass_active ? mem_rdata : fifo_head;
        data_valid    = ~fifo_empty | bypass_active;
        fifo_push     = rd_pend & ~rst & ~(bypass_active & data_ready);
        fifo_pop      = data_ready & ~fifo_empty;
    end
`else
    // All returned data goes through the FIFO; output is purely registered.
    always_comb begin
        data_out   = fifo_head;
        data_valid = ~fifo_empty;
        fifo_push  = rd_pend & ~rst;
        fifo_pop   = data_ready & ~fifo_empty;
    end
`endif

    // Track which cycle's memory read data is valid; cleared on reset so a
    // read issued just before reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_reg <= '0;
        end else begin
            rd_pend_reg <= (rd_pend_reg << 1) | MEM_RD_LAT'(accept);
        end
    end

    // Credit counter: accepted but not yet consumed loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    lsq_resp_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (mem_rdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_lsq_load_responder.sv
// Self-checking bench for lsq_load_responder: directed loads, a scoreboard
// queue filled at address acceptance and a monitor that checks every pop.
module tb_lsq_load_responder;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
`ifdef LSQ_LOAD_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_in;
    logic          addr_valid;
    logic          addr_ready;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lsq_load_responder #(
        .DATA_SIZE    (DW),
        .ADDRESS_SIZE (AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_in    (addr_in),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= (mem_addr == 32'h10) ? 32'hDEADBEEF : mem_addr + 32'h100;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record the expected response for an address accepted this cycle.
    task automatic capture(input logic [31:0] e);
        if (addr_valid && addr_ready) begin
            exp_q.push_back(e);
            $display("accept addr=%h expect=%h", addr_in, e);
        end
    endtask

    // Monitor: every consumed datum must match the oldest expected value.
    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data actual=%h required=none", data_out);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                $display("pop data=%h expect=%h", data_out, e);
                chk("data_order", data_out, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] b2b_exp [4];
        int          nacc;
        b2b_exp[0] = 32'h100;
        b2b_exp[1] = 32'h104;
        b2b_exp[2] = 32'h108;
        b2b_exp[3] = 32'h10C;

        // Reset state
        rst = 1'b1; addr_valid = 1'b1; addr_in = 32'h99; data_ready = 1'b0;
        @(negedge clk);
        chk("rst_addr_ready", addr_ready, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_data_valid", data_valid, 0);
        tick();
        rst = 1'b0; addr_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", addr_ready, 1);
        chk("post_rst_cnt", dut.cnt_reg, 0);
        chk("post_rst_valid", data_valid, 0);

        // Single load, held under backpressure, then popped
        tick();
        addr_in = 32'h10; addr_valid = 1'b1;
        @(negedge clk);
        chk("single_mem_re", mem_re, 1);
        chk("single_mem_addr", mem_addr, 32'h10);
        capture(32'hDEADBEEF);
        tick();
        addr_valid = 1'b0;
        @(negedge clk);
        chk("single_lat_cyc1", data_valid, (LAT == 1));
        tick();
        @(negedge clk);
        chk("single_valid_cyc2", data_valid, 1);
        chk("single_data_cyc2", data_out, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("single_hold", data_out, 32'hDEADBEEF);
        tick();
        data_ready = 1'b1;
        @(negedge clk);
        tick();
        data_ready = 1'b0;
        @(negedge clk);
        chk("single_cnt", dut.cnt_reg, 0);
        chk("single_empty", data_valid, 0);

        // Back-to-back loads, no bubbles
        tick();
        data_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            addr_valid = (k < 4);
            addr_in    = 32'(4 * k);
            @(negedge clk);
            if (k < 4) begin
                chk("b2b_ready", addr_ready, 1);
                capture(b2b_exp[k]);
            end
            chk("b2b_valid", data_valid, (k >= LAT && k < LAT + 4));
            tick();
        end
        addr_valid = 1'b0; data_ready = 1'b0;
        @(negedge clk);
        chk("b2b_cnt", dut.cnt_reg, 0);

        // Fill to DEPTH under backpressure
        tick();
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            addr_valid = 1'b1;
            addr_in    = 32'h20 + 32'(4 * nacc);
            @(negedge clk);
            chk("full_ready", addr_ready, (k < 4));
            if (addr_valid && addr_ready) begin
                capture(addr_in + 32'h100);
                nacc++;
            end
            tick();
        end
        chk("full_accepts", 32'(nacc), 4);
        chk("full_cnt", dut.cnt_reg, 4);
        addr_in = 32'h30; data_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", addr_ready, 0);
        tick();
        data_ready = 1'b0;
        @(negedge clk);
        chk("full_reopen", addr_ready, 1);
        capture(32'h130);
        tick();
        addr_valid = 1'b0;
        @(negedge clk);
        chk("full_again", addr_ready, 0);

        // Drain to cnt=2, then simultaneous accept and pop
        tick();
        data_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        data_ready = 1'b0;
        @(negedge clk);
        chk("simul_pre_cnt", dut.cnt_reg, 2);
        tick();
        addr_valid = 1'b1; addr_in = 32'h40; data_ready = 1'b1;
        @(negedge clk);
        capture(32'h140);
        tick();
        addr_valid = 1'b0; data_ready = 1'b0;
        @(negedge clk);
        chk("simul_cnt", dut.cnt_reg, 2);
        tick();
        data_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dut.cnt_reg == 0) break;
            tick();
        end
        chk("drain_cnt", dut.cnt_reg, 0);

        // Reset with a read in flight: the stale datum must never appear
        tick();
        addr_valid = 1'b1; addr_in = 32'h50;
        @(negedge clk);
        chk("rstmid_mem_re", mem_re, 1);
        tick();
        addr_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid_in_rst", data_valid, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstmid_valid", data_valid, 0);
            chk("rstmid_cnt", dut.cnt_reg, 0);
            tick();
        end

        // Normal operation after reset
        addr_valid = 1'b1; addr_in = 32'h14;
        @(negedge clk);
        capture(32'h114);
        tick();
        addr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && dut.cnt_reg == 0) break;
            tick();
        end
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("final_cnt", dut.cnt_reg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
